// File: rtl/costas_pkg.sv
// rtl/costas_pkg.sv - shared constants and types for the Costas phase detector
//
// Purpose: widths shared by the phase detector, lock detector and loop filter,
//          plus the lock-detector state type.
// Ports:   none (package).
package costas_pkg;

  localparam int IQ_W  = 29;  // I/Q arm sample width
  localparam int ERR_W = 58;  // phase error width
  localparam int PCW_W = 24;  // loop filter phase-control-word width

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } lock_state_e;

endpackage

// File: rtl/costas_lock_det.sv
// rtl/costas_lock_det.sv - windowed quiet-sample carrier lock detector
//
// Purpose: counts phase-error results whose magnitude is below LOCK_THR over
//          windows of LOCK_WIN results; ACQ/TRACK hysteresis FSM on the count.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   e_i      in   signed phase error (ERR_W bits)
//   strobe_i in   e_i carries a new result this cycle
//   locked_o out  carrier lock flag
module costas_lock_det
  import costas_pkg::*;
#(
  parameter int unsigned       LOCK_WIN = 1024,
  parameter logic [ERR_W-1:0]  LOCK_THR = 58'd1 << 40,
  parameter int unsigned       LOCK_ON  = 960,
  parameter int unsigned       LOCK_OFF = 768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ERR_W-1:0] e_i,
  input  logic             strobe_i,
  output logic             locked_o
);

  localparam int WIN_W = $clog2(LOCK_WIN);
  localparam int CNT_W = $clog2(LOCK_WIN + 1);

  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] quiet_q;
  logic [CNT_W-1:0] quiet_tot;
  logic [ERR_W-1:0] e_abs;
  logic             quiet;
  logic             win_end;
  lock_state_e      state_q, state_d;

  always_comb begin
    e_abs     = e_i[ERR_W-1] ? (~e_i + {{(ERR_W-1){1'b0}}, 1'b1}) : e_i;
    quiet     = (e_abs < LOCK_THR);
    // The sample that closes a window is counted in that window.
    quiet_tot = quiet_q + CNT_W'(quiet);
    win_end   = strobe_i && (win_q == WIN_W'(LOCK_WIN - 1));
  end

  always_comb begin
    state_d = state_q;
    if (win_end) begin
      case (state_q)
        ACQ:     if (quiet_tot >= CNT_W'(LOCK_ON))  state_d = TRACK;
        TRACK:   if (quiet_tot <  CNT_W'(LOCK_OFF)) state_d = ACQ;
        default: state_d = ACQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      quiet_q <= '0;
      state_q <= ACQ;
    end else begin
      state_q <= state_d;
      if (win_end) begin
        win_q   <= '0;
        quiet_q <= '0;
      end else if (strobe_i) begin
        win_q   <= win_q + WIN_W'(1);
        quiet_q <= quiet_tot;
      end
    end
  end

  assign locked_o = (state_q == TRACK);

endmodule

// File: rtl/costas_phase_detector.sv
// rtl/costas_phase_detector.sv - QPSK Costas loop phase detector, sgn(IQ)(Q^2-I^2)
//
// Purpose: 3-stage valid-gated pipeline producing a held 58-bit phase error.
//          Lock detector included when COSTAS_LOCK_DET_EN is defined.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   i_in      in   signed I-arm sample
//   q_in      in   signed Q-arm sample
//   in_valid  in   i_in/q_in valid this cycle
//   pd_err    out  signed phase error, held between updates
//   err_valid out  one-cycle strobe when pd_err updates
//   locked    out  carrier lock flag (COSTAS_LOCK_DET_EN only)
module costas_phase_detector
  import costas_pkg::*;
`ifdef COSTAS_LOCK_DET_EN
#(
  parameter int unsigned      LOCK_WIN = 1024,
  parameter logic [ERR_W-1:0] LOCK_THR = 58'd1 << 40,
  parameter int unsigned      LOCK_ON  = 960,
  parameter int unsigned      LOCK_OFF = 768
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IQ_W-1:0]  i_in,
  input  logic [IQ_W-1:0]  q_in,
  input  logic             in_valid,
  output logic [ERR_W-1:0] pd_err,
  output logic             err_valid
`ifdef COSTAS_LOCK_DET_EN
  ,
  output logic             locked
`endif
);

  localparam int SQ_W = ERR_W - 1;

  // S1
  logic [IQ_W-1:0]  i1_q, q1_q;
  logic             s1_q, v1_q;
  // S2
  logic [SQ_W-1:0]  isq_q, qsq_q, isq_d, qsq_d;
  logic             s2_q, v2_q;
  // S3
  logic [ERR_W-1:0] pd_err_q, pd_err_d;
  logic             err_valid_q;

  logic [IQ_W-1:0]  i_abs, q_abs;
  logic [ERR_W-1:0] diff;

  always_comb begin
    // |-2^28| = 2^28 still fits an unsigned 29-bit magnitude.
    i_abs = i1_q[IQ_W-1] ? (~i1_q + {{(IQ_W-1){1'b0}}, 1'b1}) : i1_q;
    q_abs = q1_q[IQ_W-1] ? (~q1_q + {{(IQ_W-1){1'b0}}, 1'b1}) : q1_q;
    isq_d = {{(SQ_W-IQ_W){1'b0}}, i_abs} * {{(SQ_W-IQ_W){1'b0}}, i_abs};
    qsq_d = {{(SQ_W-IQ_W){1'b0}}, q_abs} * {{(SQ_W-IQ_W){1'b0}}, q_abs};
    // Squares are at most 2^56, so a 58-bit difference cannot overflow and
    // its negation (+-2^56) is always representable.
    diff     = {1'b0, qsq_q} - {1'b0, isq_q};
    pd_err_d = s2_q ? ({ERR_W{1'b0}} - diff) : diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q        <= '0;
      q1_q        <= '0;
      s1_q        <= 1'b0;
      v1_q        <= 1'b0;
      isq_q       <= '0;
      qsq_q       <= '0;
      s2_q        <= 1'b0;
      v2_q        <= 1'b0;
      pd_err_q    <= '0;
      err_valid_q <= 1'b0;
    end else begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      err_valid_q <= v2_q;
      if (in_valid) begin
        i1_q <= i_in;
        q1_q <= q_in;
        s1_q <= i_in[IQ_W-1] ^ q_in[IQ_W-1];
      end
      if (v1_q) begin
        isq_q <= isq_d;
        qsq_q <= qsq_d;
        s2_q  <= s1_q;
      end
      if (v2_q) begin
        pd_err_q <= pd_err_d;
      end
    end
  end

  assign pd_err    = pd_err_q;
  assign err_valid = err_valid_q;

`ifdef COSTAS_LOCK_DET_EN
  costas_lock_det #(
    .LOCK_WIN (LOCK_WIN),
    .LOCK_THR (LOCK_THR),
    .LOCK_ON  (LOCK_ON),
    .LOCK_OFF (LOCK_OFF)
  ) u_lock_det (
    .clk      (clk),
    .rst      (rst),
    .e_i      (pd_err_q),
    .strobe_i (err_valid_q),
    .locked_o (locked)
  );
`endif

endmodule
